// File: rtl/delay_frame_dispatcher_if.sv
// Byte-stream input and delay-RAM write-port bundle for delay_frame_dispatcher.
// NUM_CH and ADDR_W here must match the values given to the dispatcher.
interface delay_frame_dispatcher_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 11
);
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic [4:0]               ga;
  logic [NUM_CH-1:0]        wr_en;
  logic [NUM_CH*ADDR_W-1:0] wr_addr;
  logic [NUM_CH*24-1:0]     wr_data;
  logic                     frame_ok;
  logic                     frame_err;
  logic [1:0]               err_code;
  logic [15:0]              ok_cnt;
  logic [15:0]              err_cnt;

  // Byte source and RAM observer side
  modport master (
    output rx_data, rx_valid, ga,
    input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, ok_cnt, err_cnt
  );

  // Dispatcher side
  modport slave (
    input  rx_data, rx_valid, ga,
    output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, ok_cnt, err_cnt
  );
endinterface

// File: rtl/delay_frame_dispatcher.sv
// Parses 11-byte delay frames (EB 9C, 8 payload bytes, checksum) and writes the
// 24-bit delay word into one of NUM_CH delay RAMs at a per-port running address.
// Frames are only acted upon when the key and the board slot (derived from the
// geographic address) match; a port-0xF, zero-delay frame rewinds all addresses.
module delay_frame_dispatcher #(
  parameter int          NUM_CH      = 4,
  parameter int          ADDR_W      = 11,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [31:0] FRAME_KEY   = 32'h02002000
) (
  input logic clk,
  input logic rst,
  delay_frame_dispatcher_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, HEAD1, PAYLOAD, CSUM} state_e;

  state_e              state_q, state_d;
  logic [2:0]          byteIdx_q, byteIdx_d;
  logic [63:0]         payload_q, payload_d;
  logic [7:0]          sum_q, sum_d;
  logic [IDLE_W-1:0]   idleCnt_q, idleCnt_d;
  logic [3:0]          slotMap_q, slotMap_d;

  logic                okEvt, errEvt, doWrite, doClear;
  logic [1:0]          errCause;
  logic [7:0]          sumFinal;

  logic [31:0]         keyField;
  logic [3:0]          slotField, portField;
  logic [23:0]         delayField;

  logic [NUM_CH-1:0]        wrEn_q;
  logic [NUM_CH*ADDR_W-1:0] wrAddr_q;
  logic [NUM_CH*24-1:0]     wrData_q;
  logic                     frameOk_q, frameErr_q;
  logic [1:0]               errCode_q;
  logic [15:0]              okCnt_q, errCnt_q;
  logic [ADDR_W-1:0]        addrCnt_q [NUM_CH];

  assign keyField   = payload_q[63:32];
  assign slotField  = payload_q[31:28];
  assign portField  = payload_q[27:24];
  assign delayField = payload_q[23:0];

  // Map the geographic address onto the crate slot number this board answers to
  always_comb begin
    slotMap_d = 4'd0;
    if (bus.ga >= 5'd2 && bus.ga <= 5'd8) begin
      slotMap_d = 4'(bus.ga - 5'd1);
    end else if (bus.ga >= 5'd10 && bus.ga <= 5'd17) begin
      slotMap_d = 4'(bus.ga - 5'd2);
    end
  end

  // Frame parser: header hunt, payload capture, checksum evaluation and idle timeout
  always_comb begin
    state_d   = state_q;
    byteIdx_d = byteIdx_q;
    payload_d = payload_q;
    sum_d     = sum_q;
    idleCnt_d = '0;
    okEvt     = 1'b0;
    errEvt    = 1'b0;
    errCause  = 2'b00;
    doWrite   = 1'b0;
    doClear   = 1'b0;
    sumFinal  = sum_q + bus.rx_data;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == 8'hEB) begin
          state_d = HEAD1;
          sum_d   = 8'hEB;
        end
      end
      HEAD1: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h9C) begin
            state_d   = PAYLOAD;
            byteIdx_d = 3'd0;
            sum_d     = sumFinal;
          end else if (bus.rx_data == 8'hEB) begin
            sum_d = 8'hEB;
          end else begin
            state_d  = IDLE;
            errEvt   = 1'b1;
            errCause = 2'b01;
          end
        end
      end
      PAYLOAD: begin
        if (bus.rx_valid) begin
          payload_d[{byteIdx_q, 3'b000} +: 8] = bus.rx_data;
          sum_d = sumFinal;
          if (byteIdx_q == 3'd7) begin
            state_d = CSUM;
          end else begin
            byteIdx_d = byteIdx_q + 3'd1;
          end
        end
      end
      CSUM: begin
        if (bus.rx_valid) begin
          state_d = IDLE;
          if (sumFinal == 8'h00) begin
            okEvt = 1'b1;
            if (keyField == FRAME_KEY && slotField == slotMap_q) begin
              if (portField == 4'hF && delayField == 24'd0) begin
                doClear = 1'b1;
              end else if (int'(portField) < NUM_CH) begin
                doWrite = 1'b1;
              end
            end
          end else begin
            errEvt   = 1'b1;
            errCause = 2'b10;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving on the very cycle the limit is reached still wins
    if (state_q != IDLE && !bus.rx_valid) begin
      if (idleCnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
        state_d  = IDLE;
        errEvt   = 1'b1;
        errCause = 2'b11;
      end else begin
        idleCnt_d = idleCnt_q + 1'b1;
      end
    end
  end

  // Parser state and registered slot map
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      byteIdx_q <= 3'd0;
      payload_q <= 64'd0;
      sum_q     <= 8'd0;
      idleCnt_q <= '0;
      slotMap_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      byteIdx_q <= byteIdx_d;
      payload_q <= payload_d;
      sum_q     <= sum_d;
      idleCnt_q <= idleCnt_d;
      slotMap_q <= slotMap_d;
    end
  end

  // Result pulses, sticky error cause and saturating frame counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameOk_q  <= 1'b0;
      frameErr_q <= 1'b0;
      errCode_q  <= 2'b00;
      okCnt_q    <= 16'd0;
      errCnt_q   <= 16'd0;
    end else begin
      frameOk_q  <= okEvt;
      frameErr_q <= errEvt;
      if (errEvt) begin
        errCode_q <= errCause;
      end
      if (okEvt && okCnt_q != 16'hFFFF) begin
        okCnt_q <= okCnt_q + 16'd1;
      end
      if (errEvt && errCnt_q != 16'hFFFF) begin
        errCnt_q <= errCnt_q + 16'd1;
      end
    end
  end

  // Per-port write strobes and running RAM addresses; data/address hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrEn_q   <= '0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      for (int p = 0; p < NUM_CH; p++) begin
        addrCnt_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_CH; p++) begin
        wrEn_q[p] <= 1'b0;
        if (doClear) begin
          addrCnt_q[p] <= '0;
        end else if (doWrite && int'(portField) == p) begin
          wrEn_q[p]                     <= 1'b1;
          wrAddr_q[p*ADDR_W +: ADDR_W]  <= addrCnt_q[p];
          wrData_q[p*24 +: 24]          <= delayField;
          addrCnt_q[p]                  <= addrCnt_q[p] + 1'b1;
        end
      end
    end
  end

  assign bus.wr_en     = wrEn_q;
  assign bus.wr_addr   = wrAddr_q;
  assign bus.wr_data   = wrData_q;
  assign bus.frame_ok  = frameOk_q;
  assign bus.frame_err = frameErr_q;
  assign bus.err_code  = errCode_q;
  assign bus.ok_cnt    = okCnt_q;
  assign bus.err_cnt   = errCnt_q;

endmodule

// File: tb/tb_delay_frame_dispatcher.sv
// Self-checking bench for delay_frame_dispatcher: directed frames for the
// headline cases followed by randomized frames, all compared against a
// frame-level reference model.
module tb_delay_frame_dispatcher;

  localparam int          NUM_CH      = 4;
  localparam int          ADDR_W      = 4;
  localparam int          TIMEOUT_CYC = 40;
  localparam logic [31:0] KEY         = 32'h02002000;

  typedef logic [7:0] frame_t [11];

  logic clk = 1'b0;
  logic rst;

  delay_frame_dispatcher_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  delay_frame_dispatcher #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC), .FRAME_KEY(KEY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int nVectors     = 0;
  int nMiscompares = 0;

  // Reference model state
  int                       mCnt [NUM_CH];
  logic [NUM_CH*ADDR_W-1:0] mAddr;
  logic [NUM_CH*24-1:0]     mData;
  int                       mOkCnt, mErrCnt;
  logic [1:0]               mErrCode;
  logic                     expOk, expErr;
  logic [NUM_CH-1:0]        expWrEn;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] slotOf(input logic [4:0] g);
    int gi;
    gi = int'(g);
    if (gi >= 2 && gi <= 8)   return 4'(gi - 1);
    if (gi >= 10 && gi <= 17) return 4'(gi - 2);
    return 4'd0;
  endfunction

  function automatic int satInc(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  task automatic modelReset();
    for (int p = 0; p < NUM_CH; p++) mCnt[p] = 0;
    mAddr    = '0;
    mData    = '0;
    mOkCnt   = 0;
    mErrCnt  = 0;
    mErrCode = 2'b00;
    expOk    = 1'b0;
    expErr   = 1'b0;
    expWrEn  = '0;
  endtask

  // Predict the outcome of one complete, well-framed 11-byte frame
  task automatic modelFrame(input frame_t frm);
    int          sum;
    logic [63:0] pl;
    int          port;
    sum = 0;
    for (int i = 0; i < 11; i++) sum += int'(frm[i]);
    for (int i = 0; i < 8; i++) pl[i*8 +: 8] = frm[2+i];
    port    = int'(pl[27:24]);
    expOk   = 1'b0;
    expErr  = 1'b0;
    expWrEn = '0;
    if (sum % 256 != 0) begin
      expErr   = 1'b1;
      mErrCode = 2'd2;
      mErrCnt  = satInc(mErrCnt);
    end else begin
      expOk  = 1'b1;
      mOkCnt = satInc(mOkCnt);
      if (pl[63:32] == KEY && pl[31:28] == slotOf(bus.ga)) begin
        if (port == 15 && pl[23:0] == 24'd0) begin
          for (int p = 0; p < NUM_CH; p++) mCnt[p] = 0;
        end else if (port < NUM_CH) begin
          expWrEn[port]                 = 1'b1;
          mAddr[port*ADDR_W +: ADDR_W]  = ADDR_W'(mCnt[port]);
          mData[port*24 +: 24]          = pl[23:0];
          mCnt[port]                    = (mCnt[port] + 1) % (1 << ADDR_W);
        end
      end
    end
  endtask

  task automatic buildFrame(input logic [31:0] key, input logic [3:0] slot, input logic [3:0] port,
                            input logic [23:0] delay, input bit corrupt, output frame_t frm);
    logic [63:0] pl;
    logic [7:0]  s;
    pl = {key, slot, port, delay};
    frm[0] = 8'hEB;
    frm[1] = 8'h9C;
    for (int i = 0; i < 8; i++) frm[2+i] = pl[i*8 +: 8];
    s = 8'd0;
    for (int i = 0; i < 10; i++) s = s + frm[i];
    frm[10] = 8'd0 - s;
    if (corrupt) frm[10] = frm[10] + 8'($urandom_range(255, 1));
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Send one frame with a random idle gap (gapMin..gapMax cycles) before each byte
  task automatic applyStimulus(input frame_t frm, input int gapMin, input int gapMax);
    for (int i = 0; i < 11; i++) sendByte(frm[i], $urandom_range(gapMax, gapMin));
  endtask

  task automatic checkFrameResult(input string tag);
    checkOutput({tag, " frame_ok"},  128'(bus.frame_ok),  128'(expOk));
    checkOutput({tag, " frame_err"}, 128'(bus.frame_err), 128'(expErr));
    checkOutput({tag, " wr_en"},     128'(bus.wr_en),     128'(expWrEn));
    checkOutput({tag, " wr_addr"},   128'(bus.wr_addr),   128'(mAddr));
    checkOutput({tag, " wr_data"},   128'(bus.wr_data),   128'(mData));
    checkOutput({tag, " err_code"},  128'(bus.err_code),  128'(mErrCode));
    checkOutput({tag, " ok_cnt"},    128'(bus.ok_cnt),    128'(mOkCnt));
    checkOutput({tag, " err_cnt"},   128'(bus.err_cnt),   128'(mErrCnt));
  endtask

  task automatic sendAndCheck(input string tag, input frame_t frm, input int gapMin, input int gapMax);
    modelFrame(frm);
    applyStimulus(frm, gapMin, gapMax);
    checkFrameResult(tag);
  endtask

  task automatic checkQuietReset(input string tag);
    checkOutput({tag, " wr_en"},     128'(bus.wr_en),     128'(0));
    checkOutput({tag, " frame_ok"},  128'(bus.frame_ok),  128'(0));
    checkOutput({tag, " frame_err"}, 128'(bus.frame_err), 128'(0));
    checkOutput({tag, " err_code"},  128'(bus.err_code),  128'(0));
    checkOutput({tag, " ok_cnt"},    128'(bus.ok_cnt),    128'(0));
    checkOutput({tag, " err_cnt"},   128'(bus.err_cnt),   128'(0));
    checkOutput({tag, " wr_addr"},   128'(bus.wr_addr),   128'(0));
    checkOutput({tag, " wr_data"},   128'(bus.wr_data),   128'(0));
  endtask

  // Directed cases followed by randomized traffic
  initial begin
    frame_t v1, v3, frm;
    int     pulses, kind, gapMax, nGarbage;
    logic [7:0] g;
    logic [3:0] slot;

    v1 = '{8'hEB, 8'h9C, 8'hEF, 8'hCD, 8'hAB, 8'h10, 8'h00, 8'h20, 8'h00, 8'h02, 8'hE0};
    v3 = v1;
    v3[10] = 8'hE1;

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.ga       = 5'd2;
    modelReset();
    repeat (3) @(negedge clk);
    checkQuietReset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] basic write frame");
    sendAndCheck("v1", v1, 0, 0);
    @(negedge clk);
    expOk = 1'b0;
    expWrEn = '0;
    checkOutput("v1 wr_en one cycle", 128'(bus.wr_en), 128'(0));
    checkOutput("v1 wr_data held", 128'(bus.wr_data), 128'(mData));

    $display("[TB] bad checksum");
    sendAndCheck("v3", v3, 0, 0);

    $display("[TB] bad header and resync");
    sendByte(8'hEB, 0);
    sendByte(8'h77, 0);
    mErrCnt  = satInc(mErrCnt);
    mErrCode = 2'd1;
    checkOutput("head err frame_err", 128'(bus.frame_err), 128'(1));
    checkOutput("head err err_code", 128'(bus.err_code), 128'(mErrCode));
    checkOutput("head err err_cnt", 128'(bus.err_cnt), 128'(mErrCnt));
    sendByte(8'hEB, 0);
    sendAndCheck("resync", v1, 0, 0);

    $display("[TB] inter-byte timeout");
    sendByte(8'hEB, 0);
    sendByte(8'h9C, 0);
    sendByte(8'hEF, 0);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    checkOutput("no early timeout", 128'(bus.frame_err), 128'(0));
    @(negedge clk);
    mErrCnt  = satInc(mErrCnt);
    mErrCode = 2'd3;
    checkOutput("timeout frame_err", 128'(bus.frame_err), 128'(1));
    checkOutput("timeout err_code", 128'(bus.err_code), 128'(mErrCode));
    checkOutput("timeout err_cnt", 128'(bus.err_cnt), 128'(mErrCnt));
    sendAndCheck("after timeout", v1, 0, 0);
    sendAndCheck("max gap", v1, TIMEOUT_CYC - 1, TIMEOUT_CYC - 1);

    $display("[TB] slot mismatch and address clear");
    bus.ga = 5'd3;
    repeat (2) @(negedge clk);
    sendAndCheck("slot miss", v1, 0, 0);
    bus.ga = 5'd2;
    repeat (2) @(negedge clk);
    buildFrame(KEY, 4'd1, 4'hF, 24'd0, 1'b0, frm);
    sendAndCheck("clear", frm, 0, 0);
    sendAndCheck("after clear", v1, 0, 0);

    $display("[TB] address wrap");
    for (int i = 0; i < (1 << ADDR_W) + 1; i++) sendAndCheck("wrap", v1, 0, 0);

    $display("[TB] randomized frames");
    for (int n = 0; n < 200; n++) begin
      if (n % 25 == 0) begin
        bus.ga = 5'($urandom_range(31, 0));
        repeat (2) @(negedge clk);
      end
      nGarbage = $urandom_range(2, 0);
      for (int k = 0; k < nGarbage; k++) begin
        g = 8'($urandom_range(255, 0));
        if (g == 8'hEB) g = 8'h00;
        sendByte(g, 0);
        checkOutput("garbage quiet", 128'({bus.frame_ok, bus.frame_err}), 128'(0));
      end
      slot = slotOf(bus.ga);
      kind = $urandom_range(9, 0);
      case (kind)
        0:       buildFrame(KEY, slot, 4'($urandom_range(3, 0)), 24'($urandom), 1'b1, frm);
        1:       buildFrame(KEY ^ 32'h1, slot, 4'($urandom_range(3, 0)), 24'($urandom), 1'b0, frm);
        2:       buildFrame(KEY, slot + 4'd1, 4'($urandom_range(3, 0)), 24'($urandom), 1'b0, frm);
        3:       buildFrame(KEY, slot, 4'($urandom_range(15, 4)), 24'($urandom), 1'b0, frm);
        4:       buildFrame(KEY, slot, 4'hF, 24'd0, 1'b0, frm);
        default: buildFrame(KEY, slot, 4'($urandom_range(3, 0)), 24'($urandom), 1'b0, frm);
      endcase
      gapMax = ($urandom_range(9, 0) == 0) ? TIMEOUT_CYC - 1 : 2;
      sendAndCheck("random", frm, 0, gapMax);
    end

    $display("[TB] reset mid-frame");
    sendByte(8'hEB, 0);
    sendByte(8'h9C, 0);
    sendByte(8'hEF, 0);
    #2 rst = 1'b1;
    #1 checkQuietReset("mid reset");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    pulses = 0;
    repeat (TIMEOUT_CYC + 5) begin
      @(negedge clk);
      if (bus.frame_ok || bus.frame_err) pulses++;
    end
    checkOutput("no pulse after reset", 128'(pulses), 128'(0));
    sendAndCheck("post reset", v1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
